alu_bennett_sequencer: RTL and testbench

Sequences the 16-bit adiabatic ALU datapath against the Bennett clock. Accepts one operation per request handshake and aligns it to the next instFlag rising edge. Holds all ALU select lines stable for one full Bennett cycle, fires the slow-clock pulses (ALU_O_Fclkpos, A_Fclkpos) at the Bennett peak, then returns the captured result on a response handshake. Sits between the instruction front-end and the ALU instance; bennett_clock drives its phase inputs.

---
 rtl/alu_bennett_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_alu_bennett_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bennett_sequencer.sv
// Launches one ALU op per request on the Bennett cycle and fires the slow clocks at the peak.
// The result returns two inst_rise events plus one clk after accept, and is held until rsp_ready.
module alu_bennett_sequencer #(
  parameter int WIDTH  = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instFlag,
  input  logic [WIDTH-1:0]  clkpos,
  input  logic [WIDTH-1:0]  clkneg,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [DATA_W-1:0] req_pc,
  input  logic [DATA_W-1:0] req_instr,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] PC_in,
  output logic [DATA_W-1:0] instr_in,
  output logic              ALU_Control0,
  output logic              ALU_Control1,
  output logic              A_mux,
  output logic              B_mux0,
  output logic              B_mux1,
  output logic              SUB,
  output logic              STL,
  output logic              Adder_Cin,
  output logic              mux3_0,
  output logic              mux3_1,
  output logic              ALU_O_Fclkpos,
  output logic              A_Fclkpos,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              out_Zero_Detect,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ARMED, RUN, CAPT, HOLD, RESP} state_t;

  typedef struct packed {
    logic c1;
    logic c0;
    logic a_mux;
    logic b_mux1;
    logic b_mux0;
    logic sub;
    logic stl;
    logic cin;
  } sel_t;

  state_t            state, next_state;
  sel_t              sel_pend, sel_q;
  logic [DATA_W-1:0] a_pend, b_pend, pc_pend, instr_pend;
  logic              instFlag_q, fclk_q;
  logic              inst_rise, peak, op_illegal;
  logic              accept, launch, fire, capture, clear, run_err;

  function automatic sel_t decode(input logic [2:0] op);
    sel_t s;
    case (op)
      3'd0:    s = sel_t'(8'b10_1_11_000);
      3'd1:    s = sel_t'(8'b10_1_11_101);
      3'd2:    s = sel_t'(8'b10_1_11_111);
      3'd3:    s = sel_t'(8'b00_1_11_000);
      3'd4:    s = sel_t'(8'b01_1_11_000);
      3'd5:    s = sel_t'(8'b10_0_01_000);
      default: s = sel_t'(8'b00_0_00_000);
    endcase
    return s;
  endfunction

  assign inst_rise  = instFlag & ~instFlag_q;
  assign peak       = (&clkpos) & ~(|clkneg);
  assign op_illegal = (req_op > 3'd5);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    launch     = 1'b0;
    fire       = 1'b0;
    capture    = 1'b0;
    clear      = 1'b0;
    run_err    = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept     = 1'b1;
        next_state = op_illegal ? RESP : ARMED;
      end
      ARMED: if (inst_rise) begin
        launch     = 1'b1;
        next_state = RUN;
      end
      // A peak wins over a coincident boundary: the ALU has seen its full ramp.
      RUN: if (peak) begin
        fire       = 1'b1;
        next_state = CAPT;
      end else if (inst_rise) begin
        run_err    = 1'b1;
        clear      = 1'b1;
        next_state = RESP;
      end
      CAPT: begin
        capture    = 1'b1;
        next_state = HOLD;
      end
      HOLD: if (inst_rise) begin
        clear      = 1'b1;
        next_state = RESP;
      end
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      instFlag_q <= 1'b0;
      fclk_q     <= 1'b0;
      sel_pend   <= '0;
      sel_q      <= '0;
      a_pend     <= '0;
      b_pend     <= '0;
      pc_pend    <= '0;
      instr_pend <= '0;
      a          <= '0;
      b          <= '0;
      PC_in      <= '0;
      instr_in   <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      instFlag_q <= instFlag;
      fclk_q     <= fire;
      if (accept) begin
        sel_pend   <= decode(req_op);
        a_pend     <= req_a;
        b_pend     <= req_b;
        pc_pend    <= req_pc;
        instr_pend <= req_instr;
        if (op_illegal) begin
          rsp_result <= '0;
          rsp_zero   <= 1'b0;
          rsp_err    <= 1'b1;
        end
      end
      if (launch) begin
        sel_q    <= sel_pend;
        a        <= a_pend;
        b        <= b_pend;
        PC_in    <= pc_pend;
        instr_in <= instr_pend;
      end
      if (capture) begin
        rsp_result <= alu_out;
        rsp_zero   <= out_Zero_Detect;
        rsp_err    <= 1'b0;
      end
      if (clear) begin
        sel_q    <= '0;
        a        <= '0;
        b        <= '0;
        PC_in    <= '0;
        instr_in <= '0;
      end
      if (run_err) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b0;
        rsp_err    <= 1'b1;
      end
    end
  end

  assign ALU_Control1  = sel_q.c1;
  assign ALU_Control0  = sel_q.c0;
  assign A_mux         = sel_q.a_mux;
  assign B_mux1        = sel_q.b_mux1;
  assign B_mux0        = sel_q.b_mux0;
  assign SUB           = sel_q.sub;
  assign STL           = sel_q.stl;
  assign Adder_Cin     = sel_q.cin;
  assign mux3_1        = 1'b0;
  assign mux3_0        = 1'b0;
  assign ALU_O_Fclkpos = fclk_q;
  assign A_Fclkpos     = fclk_q;

endmodule

// File: tb/tb_alu_bennett_sequencer.sv
// Random and directed ops against a reference of per-opcode arithmetic, with a behavioural ALU and Bennett clock.
module tb_alu_bennett_sequencer;
  localparam int WIDTH  = 13;
  localparam int DATA_W = 16;
  localparam int PERIOD = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, instFlag, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [WIDTH-1:0]  clkpos, clkneg;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_a, req_b, req_pc, req_instr;
  logic [DATA_W-1:0] a, b, PC_in, instr_in, rsp_result;
  logic              ALU_Control0, ALU_Control1, A_mux, B_mux0, B_mux1, SUB, STL, Adder_Cin;
  logic              mux3_0, mux3_1, ALU_O_Fclkpos, A_Fclkpos;
  logic [DATA_W-1:0] alu_out = 16'hbeef;
  logic              out_Zero_Detect, rsp_zero, rsp_err, busy;
  logic [7:0]        dut_sel;

  alu_bennett_sequencer #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .instFlag(instFlag), .clkpos(clkpos), .clkneg(clkneg),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_pc(req_pc), .req_instr(req_instr),
    .a(a), .b(b), .PC_in(PC_in), .instr_in(instr_in),
    .ALU_Control0(ALU_Control0), .ALU_Control1(ALU_Control1), .A_mux(A_mux),
    .B_mux0(B_mux0), .B_mux1(B_mux1), .SUB(SUB), .STL(STL), .Adder_Cin(Adder_Cin),
    .mux3_0(mux3_0), .mux3_1(mux3_1), .ALU_O_Fclkpos(ALU_O_Fclkpos), .A_Fclkpos(A_Fclkpos),
    .alu_out(alu_out), .out_Zero_Detect(out_Zero_Detect),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  assign dut_sel = {ALU_Control1, ALU_Control0, A_mux, B_mux1, B_mux0, SUB, STL, Adder_Cin};
  assign out_Zero_Detect = (alu_out == 16'h0000);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bennett clock: instFlag high for 3 clk per period, one peak cycle mid-period when enabled.
  bit peak_en = 1'b1;
  initial begin
    instFlag = 1'b0;
    clkpos   = '0;
    clkneg   = '1;
    forever begin
      for (int ph = 0; ph < PERIOD; ph++) begin
        @(posedge clk);
        #1;
        instFlag = (ph < 3);
        if (!peak_en) begin
          clkpos = '0;
          clkneg = '1;
        end else if (ph == 5) begin
          clkpos = '1;
          clkneg = '0;
        end else begin
          clkpos    = WIDTH'($urandom);
          clkpos[0] = 1'b0;
          clkneg    = WIDTH'($urandom);
        end
      end
    end
  end

  int rise_cnt = 0;
  int fclk_cnt = 0;
  bit if_prev = 1'b0;
  bit sel_seen = 1'b0;
  bit fclk_split = 1'b0;

  always @(posedge clk) begin
    if (instFlag && !if_prev) rise_cnt++;
    if_prev = instFlag;
  end

  always @(negedge clk) begin
    if (ALU_O_Fclkpos) fclk_cnt++;
    if (ALU_O_Fclkpos != A_Fclkpos) fclk_split = 1'b1;
    if (dut_sel != 8'h00 || mux3_0 || mux3_1) sel_seen = 1'b1;
  end

  // Behavioural ALU: latches its result on the slow clock from whatever selects are driven.
  function automatic logic [15:0] alu_model();
    logic [15:0] x, y, s;
    x = A_mux ? a : PC_in;
    case ({B_mux1, B_mux0})
      2'b11:   y = b;
      2'b01:   y = instr_in;
      default: y = 16'h0000;
    endcase
    s = x + (SUB ? ~y : y) + 16'(Adder_Cin);
    case ({ALU_Control1, ALU_Control0})
      2'b10:   return STL ? 16'($signed(x) < $signed(y)) : s;
      2'b00:   return x & y;
      2'b01:   return x | y;
      default: return 16'hdead;
    endcase
  endfunction

  always @(posedge ALU_O_Fclkpos) alu_out = alu_model();

  function automatic logic [15:0] ref_result(input int op, input logic [15:0] x, y, pc, ins);
    case (op)
      0:       return x + y;
      1:       return x - y;
      2:       return ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      3:       return x & y;
      4:       return x | y;
      5:       return pc + ins;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] sel_of(input int op);
    case (op)
      0:       return 8'b10111000;
      1:       return 8'b10111101;
      2:       return 8'b10111111;
      3:       return 8'b00111000;
      4:       return 8'b01111000;
      5:       return 8'b10001000;
      default: return 8'b00000000;
    endcase
  endfunction

  int          e_op, rise0, fclk0, w;
  logic [15:0] e_a, e_b, e_pc, e_ins;
  bit          e_peak;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic note_accept(input int op, input logic [15:0] x, y, pc, ins);
    e_op = op; e_a = x; e_b = y; e_pc = pc; e_ins = ins; e_peak = peak_en;
    rise0 = rise_cnt; fclk0 = fclk_cnt; sel_seen = 1'b0;
  endtask

  task automatic send(input int op, input logic [15:0] x, y, pc, ins);
    int n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    if (!req_ready) begin check_eq("req_ready_wait", 0, 1); return; end
    req_valid = 1'b1; req_op = 3'(op);
    req_a = x; req_b = y; req_pc = pc; req_instr = ins;
    step();
    req_valid = 1'b0;
    note_accept(op, x, y, pc, ins);
  endtask

  task automatic await_rsp(input string tag, output int waited);
    bit legal, ok;
    logic [15:0] r;
    waited = 0;
    while (!rsp_valid && waited < 200) begin
      if (ALU_O_Fclkpos) begin
        check_eq({tag, "_sel"}, {dut_sel, mux3_1, mux3_0}, {sel_of(e_op), 2'b00});
        check_eq({tag, "_opnd"}, {a, b, PC_in, instr_in}, {e_a, e_b, e_pc, e_ins});
      end
      step();
      waited++;
    end
    if (!rsp_valid) begin check_eq({tag, "_timeout"}, 0, 1); return; end
    legal = (e_op <= 5);
    ok    = legal && e_peak;
    r     = ref_result(e_op, e_a, e_b, e_pc, e_ins);
    check_eq({tag, "_err"}, rsp_err, !ok);
    check_eq({tag, "_fclk_pulses"}, fclk_cnt - fclk0, ok ? 1 : 0);
    if (ok) begin
      check_eq({tag, "_result"}, rsp_result, r);
      check_eq({tag, "_zero"}, rsp_zero, (r == 16'h0000));
    end
    if (legal) check_eq({tag, "_rises"}, rise_cnt - rise0, 2);
    else begin
      check_eq({tag, "_result"}, rsp_result, 0);
      check_eq({tag, "_sel_quiet"}, sel_seen, 0);
    end
    check_eq({tag, "_cleared"}, {dut_sel, a, b, PC_in, instr_in, ALU_O_Fclkpos}, 0);
  endtask

  task automatic release_rsp(input int delay);
    repeat (delay) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [17:0] snap;
    bit stable, rdy_seen;
    int n, op;
    logic [15:0] x, y;

    reset = 1'b1; req_valid = 1'b0; req_op = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_pc = '0; req_instr = '0;
    repeat (3) step();
    check_eq("rst_hs", {req_ready, rsp_valid, busy}, 3'b100);
    check_eq("rst_rsp", {rsp_result, rsp_zero, rsp_err}, 0);
    check_eq("rst_outs", {dut_sel, mux3_1, mux3_0, ALU_O_Fclkpos, A_Fclkpos, a, b, PC_in, instr_in}, 0);
    reset = 1'b0;
    step();

    send(0, 16'd1, 16'd2, 16'd0, 16'd0);          await_rsp("add", w);     release_rsp(0);
    send(1, 16'd5, 16'd5, 16'd0, 16'd0);          await_rsp("sub", w);     release_rsp(1);
    send(7, 16'h1234, 16'h4321, 16'd0, 16'd0);    await_rsp("illegal", w);
    check_eq("illegal_latency", (w <= 2), 1);                              release_rsp(0);
    peak_en = 1'b0;
    send(0, 16'd9, 16'd9, 16'd0, 16'd0);          await_rsp("nopeak", w);
    peak_en = 1'b1;                                                        release_rsp(0);
    send(5, 16'haaaa, 16'h5555, 16'h0100, 16'h0004); await_rsp("pcadd", w); release_rsp(2);

    // Backpressure: response held with a second request waiting.
    send(2, 16'hfffe, 16'h0003, 16'd0, 16'd0);    await_rsp("bp1", w);
    snap = {rsp_valid, rsp_result, rsp_zero};
    req_valid = 1'b1; req_op = 3'd4; req_a = 16'h00f0; req_b = 16'h0f00; req_pc = '0; req_instr = '0;
    stable = 1'b1; rdy_seen = 1'b0;
    repeat (20) begin
      step();
      if (req_ready) rdy_seen = 1'b1;
      if ({rsp_valid, rsp_result, rsp_zero} !== snap || rsp_err !== 1'b0) stable = 1'b0;
    end
    check_eq("bp_ready_low", rdy_seen, 0);
    check_eq("bp_rsp_stable", stable, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("bp_idle", {req_ready, rsp_valid, busy}, 3'b100);
    step();
    req_valid = 1'b0;
    check_eq("bp_accept", {req_ready, busy}, 2'b01);
    note_accept(4, 16'h00f0, 16'h0f00, 16'd0, 16'd0);
    await_rsp("bp2", w);
    release_rsp(0);

    // Reset while the result is held in HOLD.
    send(0, 16'd100, 16'd200, 16'd0, 16'd0);
    n = 0;
    while (!ALU_O_Fclkpos && n < 100) begin step(); n++; end
    check_eq("hold_fclk_seen", ALU_O_Fclkpos, 1);
    step();
    step();
    reset = 1'b1;
    step();
    check_eq("rst_hold_hs", {req_ready, rsp_valid, busy}, 3'b100);
    check_eq("rst_hold_outs", {dut_sel, ALU_O_Fclkpos, A_Fclkpos, a, b, PC_in, instr_in}, 0);
    check_eq("rst_hold_rsp", {rsp_result, rsp_zero, rsp_err}, 0);
    reset = 1'b0;
    step();
    send(0, 16'h7000, 16'h1234, 16'd0, 16'd0);    await_rsp("post_rst", w); release_rsp(0);

    for (int i = 0; i < 20; i++) begin
      op = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(6, 7);
      x  = 16'($urandom);
      y  = ($urandom_range(0, 3) == 0) ? x : 16'($urandom);
      peak_en = ($urandom_range(0, 7) != 0);
      send(op, x, y, 16'($urandom), 16'($urandom));
      await_rsp("rand", w);
      peak_en = 1'b1;
      release_rsp($urandom_range(0, 3));
    end

    check_eq("fclk_pair", fclk_split, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
